logic_bist: RTL and testbench
=============================

# logic_bist

Self-checking stimulus generator and response checker for the parameterized bitwise logic units (AND, OR, NOR, NOT). It drives one shared operand pair `a`/`b` into all four unit instances and collects their four results. It compares each result against an internal golden model and reports a pass/fail summary. The block sits beside the logic units in the built-in self-test path and replaces the hand-written stimulus/monitor flow.

## Interface
- `N_BIT`, 8: operand/result width; the LFSR is 2*N_BIT wide.
- `NUM_VECTORS`, 16: vectors per run, range 1..65535.
- `DUT_LAT`, 1: cycles from operand change to valid unit results, range 0..7.
- `SEED`, 16'hACE1: LFSR start value (2*N_BIT bits). A value of 0 is replaced by 1.
- `TAPS`, 16'hB400: Galois feedback mask (2*N_BIT bits). The default is x^16+x^14+x^13+x^11+1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled only in IDLE.
- `res_and`, `res_or`, `res_nor`, `res_not`  in  N_BIT each  unit results.
- `a`, `b`  out  N_BIT each  registered operands to all units.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  high when the last run had zero mismatches; held until the next start.
- `err_count`  out  16  number of failing vectors; saturates at 16'hFFFF.
- `fail_mask`  out  4  sticky per-unit fail flags: [0] AND, [1] OR, [2] NOR, [3] NOT.
- `first_fail_idx`  out  16  index of the first failing vector; meaningful only when `pass`=0.

## Operation
- **States:** IDLE, APPLY, CHECK, DONE.
- **IDLE → APPLY:** taken on `start`=1.
  - LFSR loads SEED; vector index loads 0.
  - `err_count`, `fail_mask` and `first_fail_idx` clear; `pass` clears.
  - `a`/`b` load SEED[2N-1:N] / SEED[N-1:0].
- **APPLY:** waits DUT_LAT cycles, then moves to CHECK. With DUT_LAT=0, APPLY is skipped and the block goes directly to CHECK.
- **CHECK:** runs for one cycle. Golden values are computed from the registered `a`/`b`: a&b, a|b, ~(a|b), ~a.
  - A per-unit mismatch sets the matching `fail_mask` bit.
  - Any mismatch increments `err_count` (saturating). If this is the first failing vector, `first_fail_idx` takes the current index.
  - If index = NUM_VECTORS-1: go to DONE.
  - Otherwise: step the LFSR, index+1, load new `a`/`b`, go to APPLY.
- **LFSR step:** if s[0]=1, s ← (s>>1) ^ TAPS; otherwise s ← s>>1. `a` = s[2N-1:N], `b` = s[N-1:0].
- **DONE:** lasts one cycle. `done`=1 and `pass`=(`err_count`==0). `a`/`b` return to 0. Next state is IDLE.
- **`start` outside IDLE:** ignored, including in DONE. A `start` held high relaunches the run one cycle after `done`.
- **Reset:** all state returns to reset values immediately and asynchronously, including mid-run.
  - `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_mask`=0, `first_fail_idx`=0.
  - State returns to IDLE and the LFSR reloads SEED.

## Timing
- Call the `start`-sampling edge E0. Vector 0 is on `a`/`b` and `busy`=1 after E0.
- Vector k is compared at edge E0 + (k+1)·(DUT_LAT+1). Vector k+1 appears after that same edge.
- `done`=1, `busy`=0 and final outputs are valid in the cycle after edge E0 + NUM_VECTORS·(DUT_LAT+1). With defaults that is 32 cycles.
- Results must be stable DUT_LAT cycles after the operands change. The checker samples them exactly once per vector.
- Status outputs update only at CHECK edges and at the start edge. There are no combinational paths from inputs to outputs.

## Test plan
- **Golden units, defaults:** units are modelled with a 1-cycle register, `start` pulsed for 1 cycle. Required: `a`=8'hAC, `b`=8'hE1 after E0; `a`=8'hE2, `b`=8'h70 two cycles later; `done` pulse 32 cycles after E0 with `pass`=1, `err_count`=0, `fail_mask`=0.
- **Single injected fault:** `res_or` bit 2 inverted during vector 3 only. Required: `err_count`=1, `fail_mask`=4'b0010, `first_fail_idx`=3, `pass`=0.
- **Stuck NOT unit:** `res_not` forced to 8'h00. Required: vector 0 fails (expected 8'h53), `first_fail_idx`=0, `fail_mask`=4'b1000. `err_count` equals the bench-model count of vectors with `a`≠8'hFF.
- **Start rules:** `start` pulsed again at vector 5 is ignored and the run ends at the normal time. `start` held high relaunches one cycle after `done`, clearing `err_count` and `fail_mask` at the relaunch edge.
- **Reset mid-run:** `rst_n` is dropped during vector 7. Required: all outputs return to reset values within the same cycle. A following `start` restarts at `a`=8'hAC, `b`=8'hE1.
- **DUT_LAT=0, purely combinational units:** required `done` exactly 16 cycles after E0, with `pass`=1.

Source files
------------

// File: rtl/logic_bist.sv
// Built-in self-test sequencer for the AND/OR/NOR/NOT logic units: drives LFSR operands,
// checks unit results against a golden model and reports a pass/fail summary.
module logic_bist #(
  parameter int                 N_BIT       = 8,
  parameter int                 NUM_VECTORS = 16,
  parameter int                 DUT_LAT     = 1,
  parameter logic [2*N_BIT-1:0] SEED        = 16'hACE1,
  parameter logic [2*N_BIT-1:0] TAPS        = 16'hB400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_BIT-1:0] res_and,
  input  logic [N_BIT-1:0] res_or,
  input  logic [N_BIT-1:0] res_nor,
  input  logic [N_BIT-1:0] res_not,
  output logic [N_BIT-1:0] a,
  output logic [N_BIT-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [3:0]       fail_mask,
  output logic [15:0]      first_fail_idx
);

  localparam int W = 2 * N_BIT;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? {{(W-1){1'b0}}, 1'b1} : SEED;
  localparam logic [2:0]   LAT_LAST = 3'((DUT_LAT > 0) ? (DUT_LAT - 1) : 0);
  localparam logic [15:0]  LAST_IDX = 16'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  localparam state_t RUN_STATE = (DUT_LAT == 0) ? CHECK : APPLY;

  state_t           state;
  logic [W-1:0]     lfsr;
  logic [W-1:0]     lfsr_next;
  logic [15:0]      idx;
  logic [2:0]       wait_cnt;
  logic [3:0]       mismatch;
  logic             any_fail;
  logic [15:0]      err_next;

  // Golden model is evaluated on the registered operands, so the compare is purely local.
  always_comb begin
    mismatch    = 4'b0000;
    mismatch[0] = (res_and != (a & b));
    mismatch[1] = (res_or  != (a | b));
    mismatch[2] = (res_nor != ~(a | b));
    mismatch[3] = (res_not != ~a);
    any_fail    = |mismatch;
    lfsr_next   = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    err_next    = err_count;
    if (any_fail && (err_count != 16'hFFFF)) begin
      err_next = err_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      lfsr           <= SEED_EFF;
      idx            <= '0;
      wait_cnt       <= '0;
      a              <= '0;
      b              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_mask      <= '0;
      first_fail_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lfsr           <= SEED_EFF;
            idx            <= '0;
            wait_cnt       <= '0;
            err_count      <= '0;
            fail_mask      <= '0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
            a              <= SEED_EFF[W-1:N_BIT];
            b              <= SEED_EFF[N_BIT-1:0];
            busy           <= 1'b1;
            state          <= RUN_STATE;
          end
        end
        APPLY: begin
          if (wait_cnt == LAT_LAST) begin
            wait_cnt <= '0;
            state    <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        CHECK: begin
          fail_mask <= fail_mask | mismatch;
          err_count <= err_next;
          if (any_fail && (err_count == '0)) begin
            first_fail_idx <= idx;
          end
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_next == '0);
            a     <= '0;
            b     <= '0;
            state <= DONE;
          end else begin
            lfsr  <= lfsr_next;
            idx   <= idx + 16'd1;
            a     <= lfsr_next[W-1:N_BIT];
            b     <= lfsr_next[N_BIT-1:0];
            state <= RUN_STATE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_bist.sv
// Directed bench for logic_bist: modelled logic units with injectable faults,
// a table of whole-run scenarios plus hand sequences for start, reset and zero latency.
module tb_logic_bist;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start0;
  int          fault_mode;
  int          compared;
  int          mismatched;

  logic [7:0]  res_and, res_or, res_nor, res_not;
  logic [7:0]  a, b;
  logic        busy, done, pass;
  logic [15:0] err_count, first_fail_idx;
  logic [3:0]  fail_mask;

  logic [7:0]  res_and0, res_or0, res_nor0, res_not0;
  logic [7:0]  a0, b0;
  logic        busy0, done0, pass0;
  logic [15:0] err_count0, first_fail_idx0;
  logic [3:0]  fail_mask0;

  logic [7:0]  r_and, r_or, r_nor, r_not;
  logic [15:0] vec [16];

  typedef struct {
    string       name;
    int          mode;
    logic        pass_exp;
    logic [15:0] err_exp;
    logic [3:0]  mask_exp;
    logic [15:0] idx_exp;
  } run_t;

  run_t tbl [5];

  always #5 clk = ~clk;

  logic_bist u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .res_and(res_and), .res_or(res_or), .res_nor(res_nor), .res_not(res_not),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask), .first_fail_idx(first_fail_idx)
  );

  logic_bist #(.DUT_LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .res_and(res_and0), .res_or(res_or0), .res_nor(res_nor0), .res_not(res_not0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err_count0), .fail_mask(fail_mask0), .first_fail_idx(first_fail_idx0)
  );

  // One-cycle registered units with selectable fault injection.
  always @(posedge clk) begin
    r_and <= a & b;
    r_or  <= a | b;
    r_nor <= ~(a | b);
    r_not <= ~a;
  end

  always_comb begin
    res_and = r_and;
    res_or  = r_or;
    res_nor = r_nor;
    res_not = r_not;
    case (fault_mode)
      1: if ({a, b} == vec[3]) res_or = r_or ^ 8'h04;
      2: res_not = 8'h00;
      3: res_and = 8'hFF;
      4: res_nor = r_nor ^ 8'h01;
      default: ;
    endcase
  end

  assign res_and0 = a0 & b0;
  assign res_or0  = a0 | b0;
  assign res_nor0 = ~(a0 | b0);
  assign res_not0 = ~a0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int mode, input bit hold, input int repulse,
                               output int done_cyc, output logic [15:0] ab_e0,
                               output logic [15:0] ab_c2, output logic busy_e0);
    fault_mode = mode;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    ab_e0    = {a, b};
    busy_e0  = busy;
    ab_c2    = 16'h0;
    done_cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) ab_c2 = {a, b};
      if (c == repulse) start = 1'b1;
      else if (repulse > 0 && c == repulse + 1) start = 1'b0;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cyc;
    int          not_fails;
    int          and_fails;
    int          and_first;
    logic [15:0] ab_e0, ab_c2;
    logic        busy_e0;

    compared   = 0;
    mismatched = 0;
    start      = 1'b0;
    start0     = 1'b0;
    fault_mode = 0;
    rst_n      = 1'b0;

    vec[0] = 16'hACE1;
    for (int k = 1; k < 16; k++) vec[k] = lfsr_step(vec[k-1]);
    not_fails = 0;
    and_fails = 0;
    and_first = -1;
    for (int k = 0; k < 16; k++) begin
      if (vec[k][15:8] != 8'hFF) not_fails++;
      if ((vec[k][15:8] & vec[k][7:0]) != 8'hFF) begin
        and_fails++;
        if (and_first < 0) and_first = k;
      end
    end

    tbl[0] = '{"clean",        0, 1'b1, 16'd0,              4'b0000, 16'd0};
    tbl[1] = '{"or_bit2_vec3", 1, 1'b0, 16'd1,              4'b0010, 16'd3};
    tbl[2] = '{"not_stuck0",   2, 1'b0, 16'(not_fails),     4'b1000, 16'd0};
    tbl[3] = '{"and_stuck1",   3, 1'b0, 16'(and_fails),     4'b0001, 16'(and_first)};
    tbl[4] = '{"nor_bit0",     4, 1'b0, 16'd16,             4'b0100, 16'd0};

    #12;
    checkOutput("reset_ab",   32'({a, b}),        32'h0);
    checkOutput("reset_busy", 32'(busy),          32'h0);
    checkOutput("reset_done", 32'(done),          32'h0);
    checkOutput("reset_pass", 32'(pass),          32'h0);
    checkOutput("reset_err",  32'(err_count),     32'h0);
    checkOutput("reset_mask", 32'(fail_mask),     32'h0);
    checkOutput("reset_idx",  32'(first_fail_idx),32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 1'b0, 0, cyc, ab_e0, ab_c2, busy_e0);
    checkOutput("e0_ab",      32'(ab_e0),   32'hACE1);
    checkOutput("e0_busy",    32'(busy_e0), 32'h1);
    checkOutput("e2_ab",      32'(ab_c2),   32'hE270);
    checkOutput("golden_done_cyc", 32'(cyc), 32'd32);
    checkOutput("golden_busy_at_done", 32'(busy), 32'h0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(tbl[i].mode, 1'b0, 0, cyc, ab_e0, ab_c2, busy_e0);
      checkOutput({tbl[i].name, "_done_cyc"}, 32'(cyc),            32'd32);
      checkOutput({tbl[i].name, "_pass"},     32'(pass),           32'(tbl[i].pass_exp));
      checkOutput({tbl[i].name, "_err"},      32'(err_count),      32'(tbl[i].err_exp));
      checkOutput({tbl[i].name, "_mask"},     32'(fail_mask),      32'(tbl[i].mask_exp));
      checkOutput({tbl[i].name, "_idx"},      32'(first_fail_idx), 32'(tbl[i].idx_exp));
    end

    // A second start pulse during vector 5 must not disturb the run.
    applyStimulus(0, 1'b0, 11, cyc, ab_e0, ab_c2, busy_e0);
    checkOutput("repulse_done_cyc", 32'(cyc),  32'd32);
    checkOutput("repulse_pass",     32'(pass), 32'h1);

    // Start held high relaunches one cycle after done and clears the status.
    applyStimulus(2, 1'b1, 0, cyc, ab_e0, ab_c2, busy_e0);
    checkOutput("hold_done_cyc", 32'(cyc), 32'd32);
    @(posedge clk);
    #1;
    checkOutput("hold_idle_busy", 32'(busy),      32'h0);
    checkOutput("hold_idle_err",  32'(err_count), 32'(not_fails));
    @(posedge clk);
    #1;
    start      = 1'b0;
    fault_mode = 0;
    checkOutput("relaunch_busy", 32'(busy),      32'h1);
    checkOutput("relaunch_err",  32'(err_count), 32'h0);
    checkOutput("relaunch_mask", 32'(fail_mask), 32'h0);
    checkOutput("relaunch_ab",   32'({a, b}),    32'hACE1);
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = c;
        break;
      end
    end
    checkOutput("relaunch_done_cyc", 32'(cyc),  32'd32);
    checkOutput("relaunch_pass",     32'(pass), 32'h1);

    // Reset dropped while vector 7 is on the operands.
    fault_mode = 2;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midrun_vec7_ab", 32'({a, b}), 32'(vec[7]));
    checkOutput("midrun_busy",    32'(busy),   32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ab",   32'({a, b}),         32'h0);
    checkOutput("rst_busy", 32'(busy),           32'h0);
    checkOutput("rst_done", 32'(done),           32'h0);
    checkOutput("rst_pass", 32'(pass),           32'h0);
    checkOutput("rst_err",  32'(err_count),      32'h0);
    checkOutput("rst_mask", 32'(fail_mask),      32'h0);
    checkOutput("rst_idx",  32'(first_fail_idx), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 0, cyc, ab_e0, ab_c2, busy_e0);
    checkOutput("after_rst_ab",       32'(ab_e0), 32'hACE1);
    checkOutput("after_rst_done_cyc", 32'(cyc),   32'd32);
    checkOutput("after_rst_pass",     32'(pass),  32'h1);

    // Zero-latency instance with combinational units.
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    checkOutput("lat0_e0_ab", 32'({a0, b0}), 32'hACE1);
    cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (done0) begin
        cyc = c;
        break;
      end
    end
    checkOutput("lat0_done_cyc", 32'(cyc),        32'd16);
    checkOutput("lat0_pass",     32'(pass0),      32'h1);
    checkOutput("lat0_err",      32'(err_count0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
